apb_wait_slave: RTL

- APB completer (slave) that responds to the team's APB master through the shared APB signal set.
- Contains a word-addressed register bank with byte-strobe writes.
- Inserts a programmable number of wait states and flags bad accesses with PSLVERR.
- Drops in wherever a bus-side responder with realistic timing is needed, for example to stress master wait-state handling.

---
 rtl/apb_pkg.sv | 24 ++
 rtl/apb_regfile.sv | 44 ++++
 rtl/apb_wait_slave.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// ============================================================================
// Module      : apb_pkg
// Description : Shared APB constants, completer state type and address check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

  typedef enum logic {IDLE, ACCESS} apb_slv_state_t;

  // Misaligned byte address or word index beyond the implemented bank.
  function automatic logic is_bad_addr(input logic [1:0]  lsb,
                                       input int unsigned idx,
                                       input int unsigned depth);
    return (lsb != 2'b00) || (idx >= depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_regfile.sv
// ============================================================================
// Module      : apb_regfile
// Description : DEPTH x 32 register bank, byte-strobe write, async read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_regfile
  import apb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         widx_i,
  input  logic [APB_DATA_W-1:0] wdata_i,
  input  logic [APB_STRB_W-1:0] wstrb_i,
  input  logic [AW-1:0]         ridx_i,
  output logic [APB_DATA_W-1:0] rdata_o
);

  logic [APB_DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < APB_STRB_W; b++) begin
        if (wstrb_i[b]) begin
          mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

`default_nettype wire

// File: rtl/apb_wait_slave.sv
// ============================================================================
// Module      : apb_wait_slave
// Description : APB completer with register bank and programmable wait states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_wait_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic [APB_DATA_W-1:0] pwdata,
  input  logic [APB_STRB_W-1:0] pstrb,
  output logic [APB_DATA_W-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int         c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] c_WAIT = 4'(WAIT_CYCLES);

  apb_slv_state_t        state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [APB_DATA_W-1:0] prdata_q, prdata_d;
  logic                  err_q, err_d;
  logic                  write_q, write_d;
  logic [c_AW-1:0]       widx_q, widx_d;
  logic [APB_DATA_W-1:0] wdata_q, wdata_d;
  logic [APB_STRB_W-1:0] strb_q, strb_d;

  logic                  w_setup;
  logic                  w_bad;
  logic                  w_rf_we;
  logic [c_AW-1:0]       w_ridx;
  logic [APB_DATA_W-1:0] w_rf_rdata;
  logic [APB_DATA_W-1:0] w_rd_word;

  // A setup is accepted from IDLE or at the closing edge of a completion.
  assign w_setup = psel && !penable &&
                   ((state_q == IDLE) || ((state_q == ACCESS) && pready_q));
  assign w_bad   = is_bad_addr(paddr[1:0], 32'(paddr[ADDR_W-1:2]), DEPTH);
  assign w_rf_we = (state_q == ACCESS) && pready_q && write_q && !err_q;
  assign w_ridx  = w_setup ? paddr[c_AW+1:2] : widx_q;

  apb_regfile #(
    .DEPTH (DEPTH),
    .AW    (c_AW)
  ) u_regfile (
    .clk_i   (pclk),
    .rst_i   (preset),
    .we_i    (w_rf_we),
    .widx_i  (widx_q),
    .wdata_i (wdata_q),
    .wstrb_i (strb_q),
    .ridx_i  (w_ridx),
    .rdata_o (w_rf_rdata)
  );

  // Forward the write retiring this edge so a zero-wait read sees it.
  always_comb begin
    w_rd_word = w_rf_rdata;
    if (w_rf_we && (widx_q == w_ridx)) begin
      for (int b = 0; b < APB_STRB_W; b++) begin
        if (strb_q[b]) begin
          w_rd_word[8*b +: 8] = wdata_q[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    err_d     = err_q;
    write_d   = write_q;
    widx_d    = widx_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;

    case (state_q)
      IDLE: begin
      end
      ACCESS: begin
        if (pready_q) begin
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else if (!psel) begin
          state_d = IDLE;
        end else if (penable && (cnt_q != 4'd0)) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
            prdata_d  = (write_q || err_q) ? '0 : w_rd_word;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (w_setup) begin
      state_d = ACCESS;
      cnt_d   = c_WAIT;
      err_d   = w_bad;
      write_d = pwrite;
      widx_d  = paddr[c_AW+1:2];
      wdata_d = pwdata;
      strb_d  = pstrb;
      if (c_WAIT == 4'd0) begin
        pready_d  = 1'b1;
        pslverr_d = w_bad;
        prdata_d  = (pwrite || w_bad) ? '0 : w_rd_word;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      err_q     <= 1'b0;
      write_q   <= 1'b0;
      widx_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      err_q     <= err_d;
      write_q   <= write_d;
      widx_q    <= widx_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
    end
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

endmodule

`default_nettype wire
